// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard for the ID stage: per-GPR pending-write counters gate issue.
// Optional macro REG_SCOREBOARD_BYPASS_EN lets a same-cycle retire clear hazards and capacity checks.
module reg_scoreboard #(
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned READ_PORTS   = 2,
    parameter int unsigned CNT_WIDTH    = 2,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             id_valid,
    input  logic [READ_PORTS-1:0]            id_read_en,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] id_read_addr,
    input  logic                             id_write_en,
    input  logic [ADDR_WIDTH-1:0]            id_write_addr,
    input  logic                             wb_valid,
    input  logic [ADDR_WIDTH-1:0]            wb_addr,
    input  logic                             flush,
    output logic                             stall,
    output logic                             id_issue,
    output logic [(2**ADDR_WIDTH)-1:0]       busy_vec,
    output logic [7:0]                       pending_total,
    output logic                             underflow_err
);

    localparam int unsigned NUM_REGS = 2**ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [7:0] INFLIGHT_MAX = 8'(MAX_INFLIGHT);

    logic [CNT_WIDTH-1:0] cnt [NUM_REGS];
    logic [7:0]           total_q;
    logic                 underflow_q;

    logic                  wb_live;
    logic                  wb_dec;
    logic                  wb_underflow;
    logic                  wr_live;
    logic                  wr_inc;
    logic                  read_hazard;
    logic                  sat_hit;
    logic                  full_hit;
    logic [ADDR_WIDTH-1:0] raddr;

    assign pending_total = total_q;
    assign underflow_err = underflow_q;

    // A retire only decrements when the register actually has a pending write.
    assign wb_live      = wb_valid && (wb_addr != '0);
    assign wb_dec       = wb_live && (cnt[wb_addr] != '0);
    assign wb_underflow = wb_live && (cnt[wb_addr] == '0) && !flush;
    assign wr_live      = id_write_en && (id_write_addr != '0);
    assign wr_inc       = id_issue && wr_live;

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_vec[r] = (cnt[r] != '0);
        end
    end

    // Source-operand hazards across all read ports.
    always_comb begin
        read_hazard = 1'b0;
        raddr       = '0;
        for (int i = 0; i < READ_PORTS; i++) begin
            raddr = id_read_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef REG_SCOREBOARD_BYPASS_EN
            if (id_read_en[i] && (raddr != '0) && (cnt[raddr] != '0) &&
                !((cnt[raddr] == CNT_ONE) && wb_valid && (wb_addr == raddr))) begin
                read_hazard = 1'b1;
            end
`else
            if (id_read_en[i] && (raddr != '0) && (cnt[raddr] != '0)) begin
                read_hazard = 1'b1;
            end
`endif
        end
    end

`ifdef REG_SCOREBOARD_BYPASS_EN
    assign sat_hit  = wr_live && (cnt[id_write_addr] == CNT_MAX) &&
                      !(wb_valid && (wb_addr == id_write_addr));
    assign full_hit = wr_live && (total_q >= INFLIGHT_MAX) && !wb_dec;
`else
    assign sat_hit  = wr_live && (cnt[id_write_addr] == CNT_MAX);
    assign full_hit = wr_live && (total_q >= INFLIGHT_MAX);
`endif

    assign stall    = id_valid && (read_hazard || sat_hit || full_hit || flush);
    assign id_issue = id_valid && !stall && !flush;

    // Counter and total update; an issue and retire to the same register cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            total_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (wb_underflow) begin
                underflow_q <= 1'b1;
            end
            if (flush) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    cnt[r] <= '0;
                end
                total_q <= '0;
            end else begin
                if (wr_inc && !(wb_dec && (wb_addr == id_write_addr))) begin
                    cnt[id_write_addr] <= cnt[id_write_addr] + CNT_ONE;
                end
                if (wb_dec && !(wr_inc && (wb_addr == id_write_addr))) begin
                    cnt[wb_addr] <= cnt[wb_addr] - CNT_ONE;
                end
                if (wr_inc && !wb_dec) begin
                    total_q <= total_q + 8'd1;
                end else if (!wr_inc && wb_dec) begin
                    total_q <= total_q - 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard with default parameters.
// Expectations follow REG_SCOREBOARD_BYPASS_EN when the bench is built with it.
module tb_reg_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [1:0]  id_read_en;
    logic [9:0]  id_read_addr;
    logic        id_write_en;
    logic [4:0]  id_write_addr;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic        flush;
    logic        stall;
    logic        id_issue;
    logic [31:0] busy_vec;
    logic [7:0]  pending_total;
    logic        underflow_err;

    int checks;
    int failures;

    reg_scoreboard dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_read_en    (id_read_en),
        .id_read_addr  (id_read_addr),
        .id_write_en   (id_write_en),
        .id_write_addr (id_write_addr),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .flush         (flush),
        .stall         (stall),
        .id_issue      (id_issue),
        .busy_vec      (busy_vec),
        .pending_total (pending_total),
        .underflow_err (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid      = 1'b0;
        id_read_en    = 2'b00;
        id_read_addr  = '0;
        id_write_en   = 1'b0;
        id_write_addr = '0;
        wb_valid      = 1'b0;
        wb_addr       = '0;
        flush         = 1'b0;
    endtask

    task automatic issue_write(input logic [4:0] a);
        idle();
        id_valid      = 1'b1;
        id_write_en   = 1'b1;
        id_write_addr = a;
        #1;
        checks++;
        if (id_issue !== 1'b1) begin
            failures++;
            $display("FAIL issue_write r%0d id_issue got=%b exp=1", a, id_issue);
        end
        tick();
        idle();
    endtask

    task automatic retire(input logic [4:0] a);
        idle();
        wb_valid = 1'b1;
        wb_addr  = a;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        checks++;
        if (busy_vec !== 32'h0) begin
            failures++;
            $display("FAIL reset_busy got=%h exp=0", busy_vec);
        end
        checks++;
        if (pending_total !== 8'd0) begin
            failures++;
            $display("FAIL reset_total got=%0d exp=0", pending_total);
        end
        checks++;
        if ({stall, id_issue, underflow_err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000", {stall, id_issue, underflow_err});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_no_hazard();
        idle();
        id_valid     = 1'b1;
        id_read_en   = 2'b11;
        id_read_addr = {5'd4, 5'd3};
        #1;
        checks++;
        if ({stall, id_issue} !== 2'b01) begin
            failures++;
            $display("FAIL no_hazard stall/issue got=%b exp=01", {stall, id_issue});
        end
        checks++;
        if (busy_vec !== 32'h0) begin
            failures++;
            $display("FAIL no_hazard_busy got=%h exp=0", busy_vec);
        end
        tick();
        idle();
    endtask

    task automatic test_raw_hazard();
        issue_write(5'd5);
        id_valid     = 1'b1;
        id_read_en   = 2'b10;
        id_read_addr = {5'd5, 5'd0};
        #1;
        checks++;
        if ({stall, id_issue} !== 2'b10) begin
            failures++;
            $display("FAIL raw_stall got=%b exp=10", {stall, id_issue});
        end
        checks++;
        if (busy_vec[5] !== 1'b1) begin
            failures++;
            $display("FAIL raw_busy5 got=%b exp=1", busy_vec[5]);
        end
        tick();
        wb_valid = 1'b1;
        wb_addr  = 5'd5;
        #1;
        checks++;
`ifdef REG_SCOREBOARD_BYPASS_EN
        if ({stall, id_issue} !== 2'b01) begin
            failures++;
            $display("FAIL raw_retire_cycle got=%b exp=01", {stall, id_issue});
        end
`else
        if ({stall, id_issue} !== 2'b10) begin
            failures++;
            $display("FAIL raw_retire_cycle got=%b exp=10", {stall, id_issue});
        end
`endif
        tick();
        wb_valid = 1'b0;
        #1;
        checks++;
        if ({stall, id_issue, busy_vec[5]} !== 3'b010) begin
            failures++;
            $display("FAIL raw_after_retire got=%b exp=010", {stall, id_issue, busy_vec[5]});
        end
        checks++;
        if (pending_total !== 8'd0) begin
            failures++;
            $display("FAIL raw_total got=%0d exp=0", pending_total);
        end
        tick();
        idle();
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) begin
            idle();
            id_valid      = 1'b1;
            id_read_en    = 2'b11;
            id_read_addr  = {5'd0, 5'd0};
            id_write_en   = 1'b1;
            id_write_addr = 5'd7;
            #1;
            checks++;
            if ({stall, id_issue} !== 2'b01) begin
                failures++;
                $display("FAIL sat_write%0d got=%b exp=01", k, {stall, id_issue});
            end
            tick();
        end
        #1;
        checks++;
        if ({stall, id_issue, pending_total} !== {2'b10, 8'd3}) begin
            failures++;
            $display("FAIL sat_fourth stall/issue/total got=%b/%b/%0d exp=1/0/3",
                     stall, id_issue, pending_total);
        end
        id_write_en = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL sat_r0_read got=%b exp=0", stall);
        end
        tick();
        for (int k = 0; k < 3; k++) retire(5'd7);
        checks++;
        if ({busy_vec[7], pending_total} !== {1'b0, 8'd0}) begin
            failures++;
            $display("FAIL sat_drain busy7/total got=%b/%0d exp=0/0", busy_vec[7], pending_total);
        end
    endtask

    task automatic test_inflight();
        for (int a = 1; a <= 4; a++) issue_write(5'(a));
        checks++;
        if ({busy_vec[4:0], pending_total} !== {5'b11110, 8'd4}) begin
            failures++;
            $display("FAIL inflight_fill busy/total got=%b/%0d exp=11110/4",
                     busy_vec[4:0], pending_total);
        end
        id_valid      = 1'b1;
        id_write_en   = 1'b1;
        id_write_addr = 5'd9;
        #1;
        checks++;
        if ({stall, id_issue} !== 2'b10) begin
            failures++;
            $display("FAIL inflight_full got=%b exp=10", {stall, id_issue});
        end
        tick();
        wb_valid = 1'b1;
        wb_addr  = 5'd2;
        #1;
        checks++;
`ifdef REG_SCOREBOARD_BYPASS_EN
        if ({stall, id_issue} !== 2'b01) begin
            failures++;
            $display("FAIL inflight_retire_cycle got=%b exp=01", {stall, id_issue});
        end
        tick();
        idle();
`else
        if ({stall, id_issue} !== 2'b10) begin
            failures++;
            $display("FAIL inflight_retire_cycle got=%b exp=10", {stall, id_issue});
        end
        tick();
        wb_valid = 1'b0;
        #1;
        checks++;
        if ({stall, id_issue} !== 2'b01) begin
            failures++;
            $display("FAIL inflight_late_issue got=%b exp=01", {stall, id_issue});
        end
        tick();
        idle();
`endif
        #1;
        checks++;
        if ({busy_vec[9], busy_vec[2], pending_total} !== {2'b10, 8'd4}) begin
            failures++;
            $display("FAIL inflight_after busy9/busy2/total got=%b/%b/%0d exp=1/0/4",
                     busy_vec[9], busy_vec[2], pending_total);
        end
        retire(5'd1);
        retire(5'd3);
        retire(5'd4);
        retire(5'd9);
        checks++;
        if ({busy_vec, pending_total} !== {32'h0, 8'd0}) begin
            failures++;
            $display("FAIL inflight_drain busy/total got=%h/%0d exp=0/0", busy_vec, pending_total);
        end
    endtask

    task automatic test_same_cycle();
        issue_write(5'd6);
        id_valid      = 1'b1;
        id_write_en   = 1'b1;
        id_write_addr = 5'd6;
        wb_valid      = 1'b1;
        wb_addr       = 5'd6;
        #1;
        checks++;
        if (id_issue !== 1'b1) begin
            failures++;
            $display("FAIL same_cycle_issue got=%b exp=1", id_issue);
        end
        tick();
        idle();
        #1;
        checks++;
        if ({busy_vec[6], pending_total} !== {1'b1, 8'd1}) begin
            failures++;
            $display("FAIL same_cycle_state busy6/total got=%b/%0d exp=1/1", busy_vec[6], pending_total);
        end
        retire(5'd6);
        checks++;
        if ({busy_vec[6], pending_total, underflow_err} !== {1'b0, 8'd0, 1'b0}) begin
            failures++;
            $display("FAIL same_cycle_drain got=%b/%0d/%b exp=0/0/0",
                     busy_vec[6], pending_total, underflow_err);
        end
    endtask

    task automatic test_underflow_flush();
        retire(5'd0);
        checks++;
        if (underflow_err !== 1'b0) begin
            failures++;
            $display("FAIL underflow_r0 got=%b exp=0", underflow_err);
        end
        retire(5'd10);
        checks++;
        if ({underflow_err, busy_vec[10], pending_total} !== {2'b10, 8'd0}) begin
            failures++;
            $display("FAIL underflow_set got=%b/%b/%0d exp=1/0/0",
                     underflow_err, busy_vec[10], pending_total);
        end
        issue_write(5'd11);
        issue_write(5'd12);
        issue_write(5'd13);
        checks++;
        if (pending_total !== 8'd3) begin
            failures++;
            $display("FAIL flush_prefill got=%0d exp=3", pending_total);
        end
        id_valid      = 1'b1;
        id_write_en   = 1'b1;
        id_write_addr = 5'd14;
        wb_valid      = 1'b1;
        wb_addr       = 5'd11;
        flush         = 1'b1;
        #1;
        checks++;
        if ({stall, id_issue} !== 2'b10) begin
            failures++;
            $display("FAIL flush_cycle got=%b exp=10", {stall, id_issue});
        end
        tick();
        idle();
        #1;
        checks++;
        if ({busy_vec, pending_total, underflow_err} !== {32'h0, 8'd0, 1'b1}) begin
            failures++;
            $display("FAIL flush_after busy/total/uf got=%h/%0d/%b exp=0/0/1",
                     busy_vec, pending_total, underflow_err);
        end
        tick();
        checks++;
        if (underflow_err !== 1'b1) begin
            failures++;
            $display("FAIL underflow_sticky got=%b exp=1", underflow_err);
        end
    endtask

    task automatic test_async_reset();
        issue_write(5'd5);
        issue_write(5'd8);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_vec, pending_total, underflow_err, stall, id_issue} !== {32'h0, 8'd0, 3'b000}) begin
            failures++;
            $display("FAIL async_reset busy/total/uf/stall/issue got=%h/%0d/%b/%b/%b exp=0/0/0/0/0",
                     busy_vec, pending_total, underflow_err, stall, id_issue);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({busy_vec, pending_total} !== {32'h0, 8'd0}) begin
            failures++;
            $display("FAIL post_reset got=%h/%0d exp=0/0", busy_vec, pending_total);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_no_hazard();
        test_raw_hazard();
        test_saturation();
        test_inflight();
        test_same_cycle();
        test_underflow_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Parametrised register-hazard scoreboard for the ID stage. It sits between the ID register-address decode and issue.
- Tracks in-flight GPR writes with a saturating counter per register.
- Stalls ID when any enabled source register has a pending write, or when tracking capacity is exhausted.
- Generalises the fixed two-read-port, 5-bit-address decode to N read ports, a configurable register-file size and bounded in-flight depth.

Parameters:
- ADDR_WIDTH, 5, register address width; the scoreboard tracks 2**ADDR_WIDTH registers.
- READ_PORTS, 2, number of source-operand read ports checked per instruction.
- CNT_WIDTH, 2, width of each per-register pending counter; maximum is 2**CNT_WIDTH-1.
- MAX_INFLIGHT, 4, maximum total pending writes across all registers, range 1..255.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds a valid instruction.
- id_read_en  in  READ_PORTS  per-port read enable.
- id_read_addr  in  READ_PORTS*ADDR_WIDTH  packed read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- id_write_en  in  1  instruction writes a GPR.
- id_write_addr  in  ADDR_WIDTH  destination register.
- wb_valid  in  1  a GPR write retires this cycle.
- wb_addr  in  ADDR_WIDTH  retiring destination.
- flush  in  1  discard all in-flight writes (exception/eret).
- stall  out  1  ID must hold this cycle.
- id_issue  out  1  instruction accepted this cycle.
- busy_vec  out  2**ADDR_WIDTH  bit r set when cnt[r] is nonzero.
- pending_total  out  8  total pending writes.
- underflow_err  out  1  sticky: a retire arrived for a register with no pending write.

Behaviour:
- Reset (rst_n low, asynchronous): all cnt[r]=0, pending_total=0, busy_vec=0, underflow_err=0. With id_valid=0, stall=0 and id_issue=0.
- Register 0:
  - never tracked;
  - writes to addr 0 do not count;
  - retires to addr 0 are ignored, with no error;
  - reads of addr 0 never hazard.
- Hazard for read port i: id_read_en[i] set, address nonzero, and cnt[addr] nonzero.
- stall is combinational from registered state and current inputs. It is asserted when id_valid and any of the following holds:
  - any read port hazards;
  - id_write_en with nonzero address and cnt[waddr] at its maximum;
  - id_write_en with nonzero address and pending_total equal to MAX_INFLIGHT.
- Also asserted when id_valid and flush are both high.
- id_issue = id_valid & ~stall & ~flush.
- Counter update on each clock edge, when flush is low:
  - increment cnt[waddr] if id_issue, id_write_en and waddr nonzero;
  - decrement cnt[wb_addr] if wb_valid, wb_addr nonzero and the count is nonzero;
  - increment and decrement on the same register in the same cycle leaves it unchanged;
  - pending_total tracks the sum of all counts the same way.
- Retire to a register whose count is already 0 (nonzero address): count stays 0 and underflow_err is set until reset.
- flush: all counters and pending_total go to 0 on the next edge. Issue and retire in that cycle are both ignored. underflow_err is not cleared.
- Latency:
  - a write issued at cycle t makes busy_vec and read hazards visible from cycle t+1;
  - a retire at cycle t clears the hazard from cycle t+1, unless the optional feature below is compiled in.
- Reset mid-operation discards all state immediately. Outputs return to their reset values without a clock.

Optional Feature:
- Macro: REG_SCOREBOARD_BYPASS_EN.
- Defined: the retire port is bypassed into the hazard check.
  - A read hazard on register r is suppressed when cnt[r]==1, wb_valid is set and wb_addr==r in the same cycle.
  - The saturation and MAX_INFLIGHT checks likewise credit a same-cycle retire.
  - Retire-to-consume latency is 0 cycles.
- Not defined: hazard checks use only registered counts, giving a 1-cycle bubble after retire. No logic is added on the wb-to-stall path.

Test Plan:
- Reset, then id_valid=1 reading regs 3 and 4 with no pending writes -> stall=0, id_issue=1, busy_vec=0.
- Issue a write to r5. Next cycle read r5 on port 1 -> stall=1 and busy_vec[5]=1. Then wb_valid with wb_addr=5 -> busy_vec[5] clears next cycle and stall drops. With REG_SCOREBOARD_BYPASS_EN, stall drops in the retire cycle itself.
- Issue 3 writes to r7 (CNT_WIDTH=2) -> cnt=3. Fourth write to r7 -> stall=1. Reads of r0 never stall throughout.
- Issue writes to r1..r4 with MAX_INFLIGHT=4 -> pending_total=4. Write to r9 -> stall=1. Retire r2 -> write to r9 issues one cycle later.
- Same-cycle issue write r6 and retire r6 with cnt[6]=1 -> cnt stays 1 and pending_total is unchanged.
- wb_valid to r10 while idle -> underflow_err=1, sticky. Then flush with 3 pending -> pending_total=0 and busy_vec=0 next cycle, and underflow_err stays 1. Drive rst_n low mid-cycle -> all outputs reset without a clock edge.
